// File: rtl/bip_loader.sv
// UART-side host interface for topbip: decodes byte commands to load program
// memory, start/stop the CPU, and dump data-memory words back over the UART.
module bip_loader #(
  parameter int         DATA_LENGTH = 16,
  parameter int         ADDR_LENGTH = 11,
  parameter logic [7:0] CMD_LOAD    = 8'h4C,
  parameter logic [7:0] CMD_RUN     = 8'h52,
  parameter logic [7:0] CMD_STOP    = 8'h53,
  parameter logic [7:0] CMD_DUMP    = 8'h44,
  parameter logic [7:0] ACK_BYTE    = 8'h06
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_done_tick,
  input  logic                   tx_done_tick,
  input  logic [DATA_LENGTH-1:0] data_from_dm,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  output logic                   reset_bip,
  output logic                   WrPM,
  output logic                   RdDM,
  output logic [ADDR_LENGTH-1:0] addrFromInterface,
  output logic [DATA_LENGTH-1:0] dataFromInterface,
  output logic                   busy
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] LD_CNT_H = 4'd1;
  localparam logic [3:0] LD_CNT_L = 4'd2;
  localparam logic [3:0] LD_HI    = 4'd3;
  localparam logic [3:0] LD_LO    = 4'd4;
  localparam logic [3:0] LD_WR    = 4'd5;
  localparam logic [3:0] ACK      = 4'd6;
  localparam logic [3:0] DUMP_AH  = 4'd7;
  localparam logic [3:0] DUMP_AL  = 4'd8;
  localparam logic [3:0] DUMP_RD  = 4'd9;
  localparam logic [3:0] DUMP_CAP = 4'd10;
  localparam logic [3:0] TX_HI    = 4'd11;
  localparam logic [3:0] TX_LO    = 4'd12;
  localparam logic [3:0] TX_WAIT  = 4'd13;

  logic [3:0]             state_reg;
  logic [3:0]             ret_reg;
  logic [7:0]             byte_hi_reg;
  logic [15:0]            count_reg;
  logic [DATA_LENGTH-1:0] word_reg;
  logic                   tx_start_reg;
  logic [7:0]             tx_data_reg;
  logic                   reset_bip_reg;
  logic                   wrpm_reg;
  logic                   rddm_reg;
  logic [ADDR_LENGTH-1:0] addr_reg;
  logic [DATA_LENGTH-1:0] data_reg;
  logic [15:0]            rx_word;

  // Every two-byte quantity arrives high byte first; the held high byte plus the
  // byte now on rx_data forms the full word.
  assign rx_word = {byte_hi_reg, rx_data};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      ret_reg       <= IDLE;
      byte_hi_reg   <= '0;
      count_reg     <= '0;
      word_reg      <= '0;
      tx_start_reg  <= 1'b0;
      tx_data_reg   <= '0;
      reset_bip_reg <= 1'b1;
      wrpm_reg      <= 1'b0;
      rddm_reg      <= 1'b0;
      addr_reg      <= '0;
      data_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (rx_done_tick) begin
            if (rx_data == CMD_LOAD) begin
              reset_bip_reg <= 1'b1;
              addr_reg      <= '0;
              state_reg     <= LD_CNT_H;
            end else if (rx_data == CMD_RUN) begin
              reset_bip_reg <= 1'b0;
            end else if (rx_data == CMD_STOP) begin
              reset_bip_reg <= 1'b1;
            end else if (rx_data == CMD_DUMP) begin
              state_reg <= DUMP_AH;
            end
          end
        end
        LD_CNT_H: begin
          if (rx_done_tick) begin
            byte_hi_reg <= rx_data;
            state_reg   <= LD_CNT_L;
          end
        end
        LD_CNT_L: begin
          if (rx_done_tick) begin
            count_reg <= rx_word;
            addr_reg  <= '0;
            state_reg <= (rx_word == 16'd0) ? ACK : LD_HI;
          end
        end
        LD_HI: begin
          if (rx_done_tick) begin
            byte_hi_reg <= rx_data;
            state_reg   <= LD_LO;
          end
        end
        LD_LO: begin
          if (rx_done_tick) begin
            data_reg  <= rx_word[DATA_LENGTH-1:0];
            wrpm_reg  <= 1'b1;
            state_reg <= LD_WR;
          end
        end
        LD_WR: begin
          // Address wraps naturally at the PM size; excess words overwrite from 0.
          wrpm_reg  <= 1'b0;
          addr_reg  <= addr_reg + 1'b1;
          count_reg <= count_reg - 16'd1;
          state_reg <= (count_reg == 16'd1) ? ACK : LD_HI;
        end
        ACK: begin
          tx_start_reg <= 1'b1;
          tx_data_reg  <= ACK_BYTE;
          ret_reg      <= IDLE;
          state_reg    <= TX_WAIT;
        end
        DUMP_AH: begin
          if (rx_done_tick) begin
            byte_hi_reg <= rx_data;
            state_reg   <= DUMP_AL;
          end
        end
        DUMP_AL: begin
          if (rx_done_tick) begin
            addr_reg  <= rx_word[ADDR_LENGTH-1:0];
            rddm_reg  <= 1'b1;
            state_reg <= DUMP_RD;
          end
        end
        DUMP_RD: begin
          rddm_reg  <= 1'b0;
          state_reg <= DUMP_CAP;
        end
        DUMP_CAP: begin
          word_reg  <= data_from_dm;
          state_reg <= TX_HI;
        end
        TX_HI: begin
          tx_start_reg <= 1'b1;
          tx_data_reg  <= word_reg[DATA_LENGTH-1 -: 8];
          ret_reg      <= TX_LO;
          state_reg    <= TX_WAIT;
        end
        TX_LO: begin
          tx_start_reg <= 1'b1;
          tx_data_reg  <= word_reg[7:0];
          ret_reg      <= IDLE;
          state_reg    <= TX_WAIT;
        end
        TX_WAIT: begin
          // A done strobe coinciding with our own start pulse cannot belong to this byte.
          tx_start_reg <= 1'b0;
          if (tx_done_tick && !tx_start_reg) begin
            state_reg <= ret_reg;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign tx_start          = tx_start_reg;
  assign tx_data           = tx_data_reg;
  assign reset_bip         = reset_bip_reg;
  assign WrPM              = wrpm_reg;
  assign RdDM              = rddm_reg;
  assign addrFromInterface = addr_reg;
  assign dataFromInterface = data_reg;
  assign busy              = (state_reg != IDLE);

endmodule

// File: tb/tb_bip_loader.sv
// Directed bench for bip_loader: command table in IDLE plus hand-written
// load, dump, wrap and async-reset sequences against UART/DM models.
module tb_bip_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done_tick = 1'b0;
  logic        tx_done_tick = 1'b0;
  logic [15:0] data_from_dm = 16'h0000;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        reset_bip;
  logic        WrPM;
  logic        RdDM;
  logic [10:0] addrFromInterface;
  logic [15:0] dataFromInterface;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bip_loader dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done_tick(rx_done_tick),
    .tx_done_tick(tx_done_tick), .data_from_dm(data_from_dm), .tx_start(tx_start),
    .tx_data(tx_data), .reset_bip(reset_bip), .WrPM(WrPM), .RdDM(RdDM),
    .addrFromInterface(addrFromInterface), .dataFromInterface(dataFromInterface),
    .busy(busy)
  );

  // DM model: 1-cycle read latency, address 5 holds 5A5A, others return their address
  always @(posedge clk) begin
    if (RdDM) data_from_dm <= (addrFromInterface == 11'd5) ? 16'h5A5A : {5'd0, addrFromInterface};
  end

  logic [10:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  logic [10:0] rd_addr_q[$];
  logic [7:0]  tx_q[$];
  int wr_rb_low = 0;
  int overlap = 0;
  int inflight_viol = 0;
  int tx_delay = 3;
  int tx_cnt = 0;
  bit inflight = 1'b0;

  // UART transmitter model and bus monitors, all sampled on the falling edge
  always @(negedge clk) begin
    tx_done_tick = 1'b0;
    if (inflight) begin
      if (tx_cnt == 0) begin
        tx_done_tick = 1'b1;
        inflight = 1'b0;
      end else begin
        tx_cnt--;
      end
    end
    if (tx_start) begin
      tx_q.push_back(tx_data);
      if (inflight) inflight_viol++;
      inflight = 1'b1;
      tx_cnt = tx_delay;
    end
    if (WrPM) begin
      wr_addr_q.push_back(addrFromInterface);
      wr_data_q.push_back(dataFromInterface);
      if (!reset_bip) wr_rb_low++;
    end
    if (RdDM) rd_addr_q.push_back(addrFromInterface);
    if (WrPM && RdDM) overlap++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] wa(input int i);
    if (i < wr_addr_q.size()) return {5'd0, wr_addr_q[i]};
    return 'x;
  endfunction

  function automatic logic [15:0] wd(input int i);
    if (i < wr_data_q.size()) return wr_data_q[i];
    return 'x;
  endfunction

  function automatic logic [7:0] tb(input int i);
    if (i < tx_q.size()) return tx_q[i];
    return 'x;
  endfunction

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    tx_q.delete();
    wr_rb_low = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_done_tick = 1'b1;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int i;
    i = 0;
    while (busy !== 1'b0 && i < max_cyc) begin
      @(negedge clk);
      i++;
    end
    chk(name, {31'd0, busy}, 32'd0);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       exp_rb;
    logic       exp_busy;
  } vec_t;

  vec_t vec[6];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{8'h52, 1'b0, 1'b0};
    vec[1] = '{8'h99, 1'b0, 1'b0};
    vec[2] = '{8'h53, 1'b1, 1'b0};
    vec[3] = '{8'h00, 1'b1, 1'b0};
    vec[4] = '{8'hFF, 1'b1, 1'b0};
    vec[5] = '{8'h52, 1'b0, 1'b0};

    // Reset state, checked while reset is still asserted
    repeat (3) @(negedge clk);
    chk("rst reset_bip", {31'd0, reset_bip}, 32'd1);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst WrPM", {31'd0, WrPM}, 32'd0);
    chk("rst RdDM", {31'd0, RdDM}, 32'd0);
    chk("rst tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst addr", {21'd0, addrFromInterface}, 32'd0);
    chk("rst data", {16'd0, dataFromInterface}, 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("post-rst reset_bip", {31'd0, reset_bip}, 32'd1);
    chk("post-rst strobes", wr_addr_q.size() + rd_addr_q.size() + tx_q.size(), 32'd0);
    $display("reset: reset_bip=%0b busy=%0b", reset_bip, busy);

    // Single-byte commands in IDLE
    for (int i = 0; i < 6; i++) begin
      send_byte(vec[i].b);
      chk($sformatf("vec%0d reset_bip", i), {31'd0, reset_bip}, {31'd0, vec[i].exp_rb});
      chk($sformatf("vec%0d busy", i), {31'd0, busy}, {31'd0, vec[i].exp_busy});
      $display("vec%0d: byte %02h -> reset_bip=%0b busy=%0b", i, vec[i].b, reset_bip, busy);
    end

    // Two-word load while the CPU was running
    clear_logs();
    send_byte(8'h4C);
    chk("load reset_bip", {31'd0, reset_bip}, 32'd1);
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD);
    for (int i = 0; i < 50 && tx_q.size() == 0; i++) @(negedge clk);
    chk("load busy during ack", {31'd0, busy}, 32'd1);
    wait_idle("load idle", 50);
    chk("load inflight at idle", {31'd0, inflight}, 32'd0);
    chk("load wr count", wr_addr_q.size(), 32'd2);
    chk("load wr0 addr", {16'd0, wa(0)}, 32'h0);
    chk("load wr0 data", {16'd0, wd(0)}, 32'h1234);
    chk("load wr1 addr", {16'd0, wa(1)}, 32'h1);
    chk("load wr1 data", {16'd0, wd(1)}, 32'hABCD);
    chk("load rb low at WrPM", wr_rb_low, 32'd0);
    chk("load tx count", tx_q.size(), 32'd1);
    chk("load tx ack", {24'd0, tb(0)}, 32'h06);
    $display("load N=2: writes=%0d ack=%02h", wr_addr_q.size(), tb(0));

    // Empty load
    clear_logs();
    send_byte(8'h4C); send_byte(8'h00); send_byte(8'h00);
    wait_idle("load0 idle", 50);
    chk("load0 wr count", wr_addr_q.size(), 32'd0);
    chk("load0 tx count", tx_q.size(), 32'd1);
    chk("load0 tx ack", {24'd0, tb(0)}, 32'h06);
    $display("load N=0: writes=%0d ack=%02h", wr_addr_q.size(), tb(0));

    // Load one word past the PM size: address wraps to 0
    clear_logs();
    send_byte(8'h4C); send_byte(8'h08); send_byte(8'h01);
    for (int i = 0; i < 2049; i++) begin
      logic [15:0] w;
      w = 16'(i) ^ 16'hA500;
      send_byte(w[15:8]);
      send_byte(w[7:0]);
    end
    wait_idle("wrap idle", 50);
    chk("wrap wr count", wr_addr_q.size(), 32'd2049);
    chk("wrap wr2047 addr", {16'd0, wa(2047)}, 32'h7FF);
    chk("wrap wr2048 addr", {16'd0, wa(2048)}, 32'h0);
    chk("wrap wr2048 data", {16'd0, wd(2048)}, 32'h0800 ^ 32'hA500);
    chk("wrap tx ack", {24'd0, tb(0)}, 32'h06);
    $display("load N=2049: writes=%0d last addr=%0h", wr_addr_q.size(), wa(2048));

    // Dump while the CPU runs; a STOP byte arriving in TX_WAIT must be dropped
    send_byte(8'h52);
    clear_logs();
    tx_delay = 10;
    send_byte(8'h44); send_byte(8'h00); send_byte(8'h05);
    repeat (3) @(posedge clk);
    send_byte(8'h53);
    wait_idle("dump idle", 100);
    chk("dump rd count", rd_addr_q.size(), 32'd1);
    chk("dump rd addr", {21'd0, (rd_addr_q.size() > 0) ? rd_addr_q[0] : 11'h7FF}, 32'h5);
    chk("dump reset_bip", {31'd0, reset_bip}, 32'd0);
    chk("dump wr count", wr_addr_q.size(), 32'd0);
    chk("dump tx count", tx_q.size(), 32'd2);
    chk("dump tx hi", {24'd0, tb(0)}, 32'h5A);
    chk("dump tx lo", {24'd0, tb(1)}, 32'h5A);
    $display("dump addr 5: tx %02h %02h", tb(0), tb(1));

    // Dump with upper address bits set: F805 truncates to 005... use 7 for distinct bytes
    clear_logs();
    tx_delay = 3;
    send_byte(8'h44); send_byte(8'hF8); send_byte(8'h07);
    wait_idle("dump2 idle", 100);
    chk("dump2 rd addr", {21'd0, (rd_addr_q.size() > 0) ? rd_addr_q[0] : 11'h7FF}, 32'h7);
    chk("dump2 tx hi", {24'd0, tb(0)}, 32'h00);
    chk("dump2 tx lo", {24'd0, tb(1)}, 32'h07);
    $display("dump addr F807: rd=%0h tx %02h %02h", (rd_addr_q.size() > 0) ? rd_addr_q[0] : 11'h7FF, tb(0), tb(1));

    // Async reset while waiting for the low data byte
    clear_logs();
    send_byte(8'h4C); send_byte(8'h00); send_byte(8'h01); send_byte(8'h12);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("arst busy", {31'd0, busy}, 32'd0);
    chk("arst reset_bip", {31'd0, reset_bip}, 32'd1);
    chk("arst WrPM", {31'd0, WrPM}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    send_byte(8'h34);
    repeat (3) @(negedge clk);
    chk("arst wr count", wr_addr_q.size(), 32'd0);
    chk("arst busy after", {31'd0, busy}, 32'd0);
    $display("async reset in LD_LO: writes=%0d busy=%0b", wr_addr_q.size(), busy);

    // Load after the interrupted one
    clear_logs();
    send_byte(8'h4C); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hBE); send_byte(8'hEF);
    wait_idle("reload idle", 50);
    chk("reload wr count", wr_addr_q.size(), 32'd1);
    chk("reload wr0 addr", {16'd0, wa(0)}, 32'h0);
    chk("reload wr0 data", {16'd0, wd(0)}, 32'hBEEF);
    chk("reload tx ack", {24'd0, tb(0)}, 32'h06);
    $display("reload N=1: writes=%0d data=%04h", wr_addr_q.size(), wd(0));

    chk("WrPM/RdDM overlap", overlap, 32'd0);
    chk("tx in-flight overlap", inflight_viol, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
